// File: rtl/array_rw_ctrl.sv
// Request-side controller for a single-port masked array: arbitrates write/read
// channels onto the RW port and returns read data through a 2-entry response buffer.
module array_rw_ctrl #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 24,
    parameter int unsigned MASK_SEG     = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clock_i,
    input  logic                reset_n_i,
    input  logic                w_valid_i,
    output logic                w_ready_o,
    input  logic [ADDR_W-1:0]   w_addr_i,
    input  logic [MASK_SEG-1:0] w_mask_i,
    input  logic [DATA_W-1:0]   w_data_i,
    input  logic                r_valid_i,
    output logic                r_ready_o,
    input  logic [ADDR_W-1:0]   r_addr_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [DATA_W-1:0]   resp_data_o,
    output logic                sram_en_o,
    output logic                sram_wmode_o,
    output logic [ADDR_W-1:0]   sram_addr_o,
    output logic [MASK_SEG-1:0] sram_wmask_o,
    output logic [DATA_W-1:0]   sram_wdata_o,
    input  logic [DATA_W-1:0]   sram_rdata_i
);

    localparam int unsigned CNT_W    = 2;
    localparam int unsigned STARVE_W = 4;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic                inflight_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                rd_ptr_q, wr_ptr_q;
    logic [DATA_W-1:0]   fifo_q [2];
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic       resp_fire;
    logic [2:0] occupancy;
    logic       rd_ok, force_rd, grant_wr, grant_rd;

    assign resp_valid_o = (count_q != '0);
    assign resp_data_o  = fifo_q[rd_ptr_q];
    assign resp_fire    = resp_valid_o && resp_ready_i;

    // Space for another read once the buffered, in-flight and popping entries settle.
    assign occupancy = 3'(count_q) + 3'(inflight_q);
    assign rd_ok     = (occupancy - 3'(resp_fire)) <= 3'd1;

    // Grant: forced read first, then writes, then ordinary reads; nothing while in reset.
    always_comb begin
        force_rd = r_valid_i && rd_ok && (starve_q == STARVE_MAX);
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (reset_n_i) begin
            if (force_rd) begin
                grant_rd = 1'b1;
            end else if (w_valid_i) begin
                grant_wr = 1'b1;
            end else if (r_valid_i && rd_ok) begin
                grant_rd = 1'b1;
            end
        end
    end

    assign w_ready_o    = grant_wr;
    assign r_ready_o    = grant_rd;
    assign sram_en_o    = grant_wr || grant_rd;
    assign sram_wmode_o = grant_wr;
    assign sram_addr_o  = grant_wr ? w_addr_i : (grant_rd ? r_addr_i : '0);
    assign sram_wmask_o = grant_wr ? w_mask_i : '0;
    assign sram_wdata_o = grant_wr ? w_data_i : '0;

    // Starvation counter and FIFO occupancy next-state.
    always_comb begin
        starve_d = starve_q;
        if (!r_valid_i || grant_rd) begin
            starve_d = '0;
        end else if (w_valid_i && grant_wr && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
        count_d = CNT_W'(count_q + CNT_W'(inflight_q) - CNT_W'(resp_fire));
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            starve_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            inflight_q <= grant_rd;
            count_q    <= count_d;
            starve_q   <= starve_d;
            // Array data is only valid this one cycle; rd_ok guarantees a free slot.
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= sram_rdata_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (resp_fire) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_array_rw_ctrl.sv
// Directed bench for array_rw_ctrl with a behavioural 256x24 masked array model.
module tb_array_rw_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        w_valid, w_ready, r_valid, r_ready;
    logic [7:0]  w_addr, r_addr, sram_addr;
    logic [1:0]  w_mask, sram_wmask;
    logic [23:0] w_data, resp_data, sram_wdata, sram_rdata;
    logic        resp_valid, resp_ready, sram_en, sram_wmode;

    int n_checks = 0;
    int n_fail   = 0;

    array_rw_ctrl dut (
        .clock_i      (clk),
        .reset_n_i    (rst_n),
        .w_valid_i    (w_valid),
        .w_ready_o    (w_ready),
        .w_addr_i     (w_addr),
        .w_mask_i     (w_mask),
        .w_data_i     (w_data),
        .r_valid_i    (r_valid),
        .r_ready_o    (r_ready),
        .r_addr_i     (r_addr),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .sram_en_o    (sram_en),
        .sram_wmode_o (sram_wmode),
        .sram_addr_o  (sram_addr),
        .sram_wmask_o (sram_wmask),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata)
    );

    always #5 clk = ~clk;

    // Array model: masked write, registered read data one cycle after the read.
    logic [23:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 24'h0;
        sram_rdata = 24'h0;
    end
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wmode) begin
                if (sram_wmask[0]) mem[sram_addr][11:0]  <= sram_wdata[11:0];
                if (sram_wmask[1]) mem[sram_addr][23:12] <= sram_wdata[23:12];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_data"},  32'(resp_data),  32'd0);
        check({tag, "_sram_en"},    32'(sram_en),    32'd0);
        check({tag, "_sram_wmode"}, 32'(sram_wmode), 32'd0);
        check({tag, "_sram_addr"},  32'(sram_addr),  32'd0);
        check({tag, "_sram_wmask"}, 32'(sram_wmask), 32'd0);
        check({tag, "_sram_wdata"}, 32'(sram_wdata), 32'd0);
        check({tag, "_w_ready"},    32'(w_ready),    32'd0);
        check({tag, "_r_ready"},    32'(r_ready),    32'd0);
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic do_write(input logic [7:0] a, input logic [23:0] d, input logic [1:0] m);
        w_valid = 1'b1; w_addr = a; w_data = d; w_mask = m;
        @(negedge clk);
        check("wr_w_ready",    32'(w_ready),    32'd1);
        check("wr_sram_wmode", 32'(sram_wmode), 32'd1);
        check("wr_sram_addr",  32'(sram_addr),  32'(a));
        check("wr_sram_wmask", 32'(sram_wmask), 32'(m));
        check("wr_sram_wdata", 32'(sram_wdata), 32'(d));
        step();
        w_valid = 1'b0;
    endtask

    // Single read with latency check; resp_ready must be 1.
    task automatic do_read(input logic [7:0] a, input logic [23:0] exp);
        r_valid = 1'b1; r_addr = a;
        @(negedge clk);
        check("rd_r_ready",    32'(r_ready),    32'd1);
        check("rd_sram_en",    32'(sram_en),    32'd1);
        check("rd_sram_wmode", 32'(sram_wmode), 32'd0);
        check("rd_sram_addr",  32'(sram_addr),  32'(a));
        check("rd_sram_wdata", 32'(sram_wdata), 32'd0);
        step();
        r_valid = 1'b0;
        @(negedge clk);
        check("rd_lat1_valid", 32'(resp_valid), 32'd0);
        step();
        @(negedge clk);
        check("rd_lat2_valid", 32'(resp_valid), 32'd1);
        check("rd_lat2_data",  32'(resp_data),  32'(exp));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nresp, first, last, acc, ra, wd;
        rst_n = 1'b0; w_valid = 1'b1; r_valid = 1'b1; resp_ready = 1'b0;
        w_addr = 8'h33; r_addr = 8'h44; w_mask = 2'b11; w_data = 24'h123456;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        w_valid = 1'b0; r_valid = 1'b0; resp_ready = 1'b1;
        rst_n = 1'b1;
        step();

        // Write then read the following cycle returns new data.
        do_write(8'h10, 24'hABC123, 2'b11);
        do_read(8'h10, 24'hABC123);

        // Zero mask is a no-op write.
        do_write(8'h10, 24'h123456, 2'b00);
        do_read(8'h10, 24'hABC123);

        // Mask merge: low segment cleared only.
        do_write(8'h20, 24'hFFFFFF, 2'b11);
        do_write(8'h20, 24'h000000, 2'b01);
        do_read(8'h20, 24'hFFF000);

        // Streaming: 16 back-to-back reads.
        for (int i = 0; i < 16; i++) do_write(8'(32'h40 + i), 24'(32'h5A0000 + i), 2'b11);
        nresp = 0; first = -1; last = -1;
        for (int c = 0; c < 22; c++) begin
            r_valid = (c < 16);
            r_addr  = 8'(32'h40 + c);
            @(negedge clk);
            if (c < 16) check("stream_r_ready", 32'(r_ready), 32'd1);
            if (resp_valid) begin
                check("stream_data", 32'(resp_data), 32'(32'h5A0000 + nresp));
                if (first < 0) first = c;
                last = c;
                nresp++;
            end
            step();
        end
        r_valid = 1'b0;
        check("stream_count", 32'(nresp), 32'd16);
        check("stream_first", 32'(first), 32'd2);
        check("stream_span",  32'(last - first), 32'd15);

        // Backpressure: only two reads accepted, writes still flow.
        resp_ready = 1'b0; acc = 0; ra = 0;
        for (int c = 0; c < 6; c++) begin
            r_valid = 1'b1;
            r_addr  = 8'(32'h40 + ra);
            @(negedge clk);
            if (r_ready) begin acc++; ra++; end
            step();
        end
        check("bp_accepted", 32'(acc), 32'd2);
        r_addr = 8'(32'h40 + ra);
        w_valid = 1'b1; w_addr = 8'hF0; w_data = 24'h0F0F0F; w_mask = 2'b11;
        @(negedge clk);
        check("bp_full_w_ready", 32'(w_ready), 32'd1);
        check("bp_full_valid",   32'(resp_valid), 32'd1);
        step();
        w_valid = 1'b0;
        @(negedge clk);
        check("bp_full_r_ready", 32'(r_ready), 32'd0);
        step();
        resp_ready = 1'b1; nresp = 0;
        for (int c = 0; c < 20; c++) begin
            r_valid = (ra < 6);
            r_addr  = 8'(32'h40 + ra);
            @(negedge clk);
            if (resp_valid) begin
                check("bp_data", 32'(resp_data), 32'(32'h5A0000 + nresp));
                nresp++;
            end
            if (r_valid && r_ready) ra++;
            step();
        end
        r_valid = 1'b0;
        check("bp_resp_count", 32'(nresp), 32'd6);
        check("bp_read_count", 32'(ra), 32'd6);

        // Starvation: reads forced on cycles 5 and 10; the forced read sees old data.
        step(); step();
        wd = 1; nresp = 0;
        for (int c = 1; c <= 14; c++) begin
            w_valid = (c <= 10); r_valid = (c <= 10);
            w_addr = 8'h90; r_addr = 8'h90; w_mask = 2'b11; w_data = 24'(wd);
            @(negedge clk);
            if (c <= 10) begin
                check("starve_r_ready", 32'(r_ready), 32'(c == 5 || c == 10));
                check("starve_w_ready", 32'(w_ready), 32'(!(c == 5 || c == 10)));
            end
            if (resp_valid) begin
                check("starve_data", 32'(resp_data), (nresp == 0) ? 32'd4 : 32'd8);
                nresp++;
            end
            if (w_valid && w_ready) wd++;
            step();
        end
        w_valid = 1'b0; r_valid = 1'b0;
        check("starve_resp_count", 32'(nresp), 32'd2);

        // Reset mid-operation with one buffered and one in-flight read.
        resp_ready = 1'b0; r_valid = 1'b1; r_addr = 8'h41;
        step(); step();
        @(negedge clk);
        check("rst_pre_r_ready", 32'(r_ready),    32'd0);
        check("rst_pre_valid",   32'(resp_valid), 32'd1);
        w_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        w_valid = 1'b0; r_valid = 1'b0; resp_ready = 1'b1;
        rst_n = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("postrst_no_stale", 32'(resp_valid), 32'd0);
            step();
        end
        do_read(8'h45, 24'h5A0005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
